bch_eras_source: RTL and testbench

//  Erasure input stage ahead of the two parallel BCH decoders.

---
 rtl/bch_eras_source_if.sv | 43 ++++
 rtl/bch_eras_source.sv | 143 ++++++++++++++
 tb/tb_bch_eras_source.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/bch_eras_source_if.sv
// Stream and RAM-write bundle of the BCH erasure input stage.
// master = upstream source / testbench side, slave = bch_eras_source.
interface bch_eras_source_if #(
  parameter int m     = 4,
  parameter int ptr_w = 1
);
  // input stream and buffer handshake
  logic             isop;
  logic             ival;
  logic             ieop;
  logic             idat;
  logic             iera;
  logic             ordy;
  logic             irelease;
  // RAM write port
  logic             owrite;
  logic [m-1:0]     owaddr;
  logic [ptr_w-1:0] owptr;
  logic [1:0]       owdat;
  logic             owdat_nfixed;
  // decoder stream
  logic             osop;
  logic             oval;
  logic             oeop;
  logic [1:0]       odat;
  // frame status
  logic             odone;
  logic [ptr_w-1:0] optr;
  logic [m-1:0]     oeras_num;
  logic             oerr;

  modport master (
    output isop, ival, ieop, idat, iera, irelease,
    input  ordy, owrite, owaddr, owptr, owdat, owdat_nfixed,
    input  osop, oval, oeop, odat, odone, optr, oeras_num, oerr
  );

  modport slave (
    input  isop, ival, ieop, idat, iera, irelease,
    output ordy, owrite, owaddr, owptr, owdat, owdat_nfixed,
    output osop, oval, oeop, odat, odone, optr, oeras_num, oerr
  );
endinterface

// File: rtl/bch_eras_source.sv
// Erasure input stage for the two parallel BCH decoders.
// Writes each frame into a multi-buffer RAM as erasures->0 / erasures->1 /
// raw images, streams the two filled copies to the decoders and reports
// buffer pointer plus saturated erasure count when a frame is complete.
module bch_eras_source #(
  parameter int m     = 4,
  parameter int n     = 15,
  parameter int d     = 7,
  parameter int ptr_w = 1
)(
  input  logic              iclk,
  input  logic              ireset_n,
  input  logic              iclkena,
  bch_eras_source_if.slave  bus
);

  localparam int             NBUF   = 2**ptr_w;
  localparam logic [ptr_w:0] NBUF_L = (ptr_w+1)'(NBUF);
  localparam logic [m-1:0]   LAST   = m'(n-1);
  localparam logic [m-1:0]   SAT    = m'(d-1);

  // bit [0]: erasure forced to 0, bit [1]: erasure forced to 1
  function automatic logic [1:0] map_bits(input logic dat, input logic era);
    return era ? 2'b10 : {dat, dat};
  endfunction

  logic [m-1:0]     cnt_q, cnt_d;
  logic [m-1:0]     eras_q, eras_d;
  logic [ptr_w-1:0] wptr_q, wptr_d;
  logic [ptr_w:0]   used_q, used_d;
  logic             close_q;

  logic             owrite_q, osop_q, oeop_q, nfixed_q, odone_q, oerr_q, ordy_q;
  logic [m-1:0]     owaddr_q, oeras_q;
  logic [ptr_w-1:0] owptr_q, optr_q;
  logic [1:0]       owdat_q;

  logic             accept_s, last_s, close_s, err_s, rel_s;
  logic [m-1:0]     idx_s, eras_base_s, eras_new_s;

  // Accept decode, bit index, erasure count, framing errors and occupancy next-state
  always_comb begin
    accept_s    = bus.ival & ordy_q & iclkena;
    rel_s       = bus.irelease & iclkena;
    idx_s       = bus.isop ? {m{1'b0}} : cnt_q;
    last_s      = (idx_s == LAST);
    close_s     = accept_s & last_s;
    eras_base_s = bus.isop ? {m{1'b0}} : eras_q;
    if (bus.iera && (eras_base_s < SAT)) begin
      eras_new_s = eras_base_s + m'(1);
    end else begin
      eras_new_s = eras_base_s;
    end
    // restart mid-frame, missing eop on the closing bit, or eop too early
    err_s = (bus.isop & (cnt_q != {m{1'b0}})) | (last_s ^ bus.ieop);

    cnt_d  = cnt_q;
    eras_d = eras_q;
    wptr_d = wptr_q;
    if (accept_s) begin
      if (last_s) begin
        cnt_d  = {m{1'b0}};
        eras_d = {m{1'b0}};
        wptr_d = wptr_q + ptr_w'(1);
      end else begin
        cnt_d  = idx_s + m'(1);
        eras_d = eras_new_s;
      end
    end else begin
      cnt_d  = cnt_q;
    end

    used_d = used_q;
    if (close_s && !rel_s) begin
      used_d = used_q + (ptr_w+1)'(1);
    end else if (rel_s && !close_s && (used_q != {(ptr_w+1){1'b0}})) begin
      used_d = used_q - (ptr_w+1)'(1);
    end else begin
      used_d = used_q;
    end
  end

  // Frame state, occupancy and all registered outputs; everything holds while iclkena is low
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      cnt_q    <= {m{1'b0}};
      eras_q   <= {m{1'b0}};
      wptr_q   <= {ptr_w{1'b0}};
      used_q   <= {(ptr_w+1){1'b0}};
      close_q  <= 1'b0;
      owrite_q <= 1'b0;
      owaddr_q <= {m{1'b0}};
      owptr_q  <= {ptr_w{1'b0}};
      owdat_q  <= 2'b00;
      nfixed_q <= 1'b0;
      osop_q   <= 1'b0;
      oeop_q   <= 1'b0;
      odone_q  <= 1'b0;
      optr_q   <= {ptr_w{1'b0}};
      oeras_q  <= {m{1'b0}};
      oerr_q   <= 1'b0;
      ordy_q   <= 1'b1;
    end else if (iclkena) begin
      cnt_q    <= cnt_d;
      eras_q   <= eras_d;
      wptr_q   <= wptr_d;
      used_q   <= used_d;
      close_q  <= close_s;
      ordy_q   <= (used_d < NBUF_L);
      owrite_q <= accept_s;
      osop_q   <= accept_s & bus.isop;
      oeop_q   <= accept_s & bus.ieop;
      oerr_q   <= accept_s & err_s;
      odone_q  <= close_q;
      if (accept_s) begin
        owaddr_q <= idx_s;
        owptr_q  <= wptr_q;
        owdat_q  <= map_bits(bus.idat, bus.iera);
        nfixed_q <= bus.idat;
      end
      if (close_s) begin
        optr_q  <= wptr_q;
        oeras_q <= eras_new_s;
      end
    end
  end

  assign bus.ordy         = ordy_q;
  assign bus.owrite       = owrite_q;
  assign bus.owaddr       = owaddr_q;
  assign bus.owptr        = owptr_q;
  assign bus.owdat        = owdat_q;
  assign bus.owdat_nfixed = nfixed_q;
  assign bus.osop         = osop_q;
  assign bus.oval         = owrite_q;
  assign bus.oeop         = oeop_q;
  assign bus.odat         = owdat_q;
  assign bus.odone        = odone_q;
  assign bus.optr         = optr_q;
  assign bus.oeras_num    = oeras_q;
  assign bus.oerr         = oerr_q;

endmodule

// File: tb/tb_bch_eras_source.sv
// Bench for bch_eras_source: hand-derived vector table, directed corner
// sequences and a randomized run against a frame-level reference model.
module tb_bch_eras_source;
  localparam int M = 4, N = 15, D = 7, PW = 1, NBUF = 2;

  logic iclk = 1'b0, ireset_n = 1'b0, iclkena = 1'b1;
  always #5 iclk = ~iclk;

  bch_eras_source_if #(.m(M), .ptr_w(PW)) bus ();
  bch_eras_source #(.m(M), .n(N), .d(D), .ptr_w(PW)) dut (
    .iclk(iclk), .ireset_n(ireset_n), .iclkena(iclkena), .bus(bus)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: frame position, erasures, buffer occupancy, pending report
  int   m_pos, m_eras, m_used, m_wptr, m_pend_ptr, m_pend_eras;
  bit   m_pend;
  bit   x_write, x_err, x_done, x_rdy, x_sop, x_eop, x_nf;
  int   x_addr, x_ptr, x_optr, x_eras;
  logic [1:0] x_wdat;

  task automatic model_reset();
    m_pos = 0; m_eras = 0; m_used = 0; m_wptr = 0; m_pend = 0;
    x_write = 0; x_err = 0; x_done = 0; x_rdy = 1;
  endtask

  task automatic model_edge(input bit sop, val, eop, dat, era, rel, en);
    int  idx, e;
    bit  close;
    if (!en) return;
    close = 0;
    x_write = 0; x_err = 0; x_done = 0;
    if (m_pend) begin
      x_done = 1; x_optr = m_pend_ptr; x_eras = m_pend_eras; m_pend = 0;
    end
    if (val && (m_used < NBUF)) begin
      idx = sop ? 0 : m_pos;
      e   = (sop ? 0 : m_eras) + (era ? 1 : 0);
      if (e > D-1) e = D-1;
      x_write = 1; x_addr = idx; x_ptr = m_wptr; x_nf = dat;
      x_wdat = era ? 2'b10 : {dat, dat};
      x_sop = sop; x_eop = eop;
      x_err = (sop && m_pos != 0) || ((idx == N-1) != eop);
      if (idx == N-1) begin
        close = 1; m_pend = 1; m_pend_ptr = m_wptr; m_pend_eras = e;
        m_wptr = (m_wptr + 1) % NBUF; m_pos = 0; m_eras = 0;
      end else begin
        m_pos = idx + 1; m_eras = e;
      end
    end
    if (close && !rel) m_used++;
    else if (rel && !close && m_used > 0) m_used--;
    x_rdy = (m_used < NBUF);
  endtask

  task automatic compare_model();
    chk("owrite", bus.owrite, x_write);
    chk("oval", bus.oval, x_write);
    chk("oerr", bus.oerr, x_err);
    chk("odone", bus.odone, x_done);
    chk("ordy", bus.ordy, x_rdy);
    if (x_write) begin
      chk("owaddr", bus.owaddr, x_addr);
      chk("owptr", bus.owptr, x_ptr);
      chk("owdat", bus.owdat, x_wdat);
      chk("odat", bus.odat, x_wdat);
      chk("owdat_nfixed", bus.owdat_nfixed, x_nf);
      chk("osop", bus.osop, x_sop);
      chk("oeop", bus.oeop, x_eop);
    end
    if (x_done) begin
      chk("optr", bus.optr, x_optr);
      chk("oeras_num", bus.oeras_num, x_eras);
    end
  endtask

  task automatic step(input bit sop, val, eop, dat, era, rel);
    bus.isop = sop; bus.ival = val; bus.ieop = eop;
    bus.idat = dat; bus.iera = era; bus.irelease = rel;
    @(posedge iclk); #1;
    model_edge(sop, val, eop, dat, era, rel, iclkena);
    compare_model();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic send_frame(input logic [15:0] era_m, input logic [15:0] dat_m,
                            input bit rel_last, output int first_ptr);
    first_ptr = -1;
    for (int i = 0; i < N; i++) begin
      step(i == 0, 1, i == N-1, dat_m[i], era_m[i], rel_last && (i == N-1));
      if (i == 0) first_ptr = bus.owptr;
    end
  endtask

  task automatic do_reset();
    ireset_n = 1'b0; #3;
    model_reset();
    ireset_n = 1'b1;
  endtask

  typedef struct {
    bit sop, val, eop, dat, era, rel;
    bit ewr; int eaddr; int eptr; logic [1:0] ewdat;
    bit edone; int eeras; bit erdy;
  } vec_t;
  vec_t tbl[32];

  initial begin
    int p;
    bit b, er;
    bus.isop = 0; bus.ival = 0; bus.ieop = 0; bus.idat = 0; bus.iera = 0; bus.irelease = 0;
    model_reset();
    #12;
    // reset state
    chk("rst_ordy", bus.ordy, 1);
    chk("rst_owrite", bus.owrite, 0);
    chk("rst_odone", bus.odone, 0);
    chk("rst_oerr", bus.oerr, 0);
    chk("rst_oeras", bus.oeras_num, 0);
    ireset_n = 1'b1;
    @(negedge iclk);

    // table: frame A 1,0,1.. clean; frame B all ones, erasures at 2,5,9
    for (int i = 0; i < N; i++) begin
      b = (i % 2 == 0);
      tbl[i] = '{sop: i == 0, val: 1, eop: i == N-1, dat: b, era: 0, rel: 0,
                 ewr: 1, eaddr: i, eptr: 0, ewdat: {b, b}, edone: 0, eeras: 0, erdy: 1};
      er = (i == 2) || (i == 5) || (i == 9);
      tbl[16+i] = '{sop: i == 0, val: 1, eop: i == N-1, dat: 1, era: er, rel: 0,
                    ewr: 1, eaddr: i, eptr: 1, ewdat: er ? 2'b10 : 2'b11,
                    edone: 0, eeras: 0, erdy: i != N-1};
    end
    tbl[15] = '{sop: 0, val: 0, eop: 0, dat: 0, era: 0, rel: 0, ewr: 0, eaddr: 0,
                eptr: 0, ewdat: 2'b00, edone: 1, eeras: 0, erdy: 1};
    tbl[31] = '{sop: 0, val: 0, eop: 0, dat: 0, era: 0, rel: 0, ewr: 0, eaddr: 0,
                eptr: 1, ewdat: 2'b00, edone: 1, eeras: 3, erdy: 0};
    for (int k = 0; k < 32; k++) begin
      step(tbl[k].sop, tbl[k].val, tbl[k].eop, tbl[k].dat, tbl[k].era, tbl[k].rel);
      chk("tbl_owrite", bus.owrite, tbl[k].ewr);
      if (tbl[k].ewr) begin
        chk("tbl_owaddr", bus.owaddr, tbl[k].eaddr);
        chk("tbl_owptr", bus.owptr, tbl[k].eptr);
        chk("tbl_owdat", bus.owdat, tbl[k].ewdat);
        chk("tbl_odat", bus.odat, tbl[k].ewdat);
        chk("tbl_nfixed", bus.owdat_nfixed, tbl[k].dat);
      end
      chk("tbl_odone", bus.odone, tbl[k].edone);
      if (tbl[k].edone) begin
        chk("tbl_optr", bus.optr, tbl[k].eptr);
        chk("tbl_oeras", bus.oeras_num, tbl[k].eeras);
      end
      chk("tbl_ordy", bus.ordy, tbl[k].erdy);
    end

    // both buffers full: third frame held off, bits dropped
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 1, 0, 0);
      chk("held_owrite", bus.owrite, 0);
    end
    step(1, 1, 0, 1, 0, 1);
    chk("release_ordy", bus.ordy, 1);
    chk("release_owrite", bus.owrite, 0);
    // third frame into buffer 0, release coincident with its close
    send_frame(16'h0000, 16'h5555, 1, p);
    chk("third_ptr", p, 0);
    idle();
    chk("third_done", bus.odone, 1);
    chk("third_optr", bus.optr, 0);
    chk("coincident_ordy", bus.ordy, 1);
    step(0, 0, 0, 0, 0, 1);

    // 8 erasures saturate at d-1
    send_frame(16'h00FF, 16'h7FFF, 0, p);
    idle();
    chk("sat_done", bus.odone, 1);
    chk("sat_eras", bus.oeras_num, D-1);
    step(0, 0, 0, 0, 0, 1);

    // isop at cnt=7 restarts the frame
    for (int i = 0; i < 7; i++) step(i == 0, 1, 0, 1, 1, 0);
    step(1, 1, 0, 0, 0, 0);
    chk("restart_oerr", bus.oerr, 1);
    chk("restart_addr", bus.owaddr, 0);
    for (int i = 1; i < N; i++) step(0, 1, i == N-1, 1, i == 3, 0);
    idle();
    chk("restart_done", bus.odone, 1);
    chk("restart_eras", bus.oeras_num, 1);
    step(0, 0, 0, 0, 0, 1);

    // randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      bit sop, eop;
      int idx;
      iclkena = ($urandom % 16) != 0;
      sop = ($urandom % 20) == 0;
      idx = sop ? 0 : m_pos;
      eop = (idx == N-1);
      if (($urandom % 10) == 0) eop = ~eop;
      step(sop, ($urandom % 4) != 0, eop, $urandom % 2, ($urandom % 5) == 0,
           ($urandom % 8) == 0);
    end
    iclkena = 1'b1;

    // reset in the middle of a frame
    do_reset();
    @(negedge iclk);
    for (int i = 0; i < 5; i++) step(i == 0, 1, 0, 1, 0, 0);
    ireset_n = 1'b0; #2;
    chk("midrst_owrite", bus.owrite, 0);
    chk("midrst_ordy", bus.ordy, 1);
    chk("midrst_odone", bus.odone, 0);
    model_reset();
    ireset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("midrst_nodone", bus.odone, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
